// File: rtl/snax_csr_master.sv
// ============================================================================
// Module   : snax_csr_master
// Purpose  : Queues host CSR commands in a small FIFO and replays them in
//            order to a CSR manager through a valid/ready request channel.
//            Only one read is outstanding at a time. Its response is handed
//            back to the host through a held rd_data/rd_valid handshake.
// Options  : SNAX_CSR_MASTER_TIMEOUT_EN - when defined, a read that is not
//            answered within TimeoutCycles returns 32'hDEAD_BEEF and sets a
//            sticky err_o. When undefined, a read waits for its response
//            indefinitely and err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snax_csr_master #(
    parameter int FifoDepth     = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    input  logic        cmd_write_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [31:0] csr_req_addr_o,
    output logic [31:0] csr_req_data_o,
    output logic        csr_req_write_o,
    output logic        csr_req_valid_o,
    input  logic        csr_req_ready_i,
    input  logic [31:0] csr_rsp_data_i,
    input  logic        csr_rsp_valid_i,
    output logic        csr_rsp_ready_o,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e state;
    state_e state_next;

    logic [31:0]          fifo_addr [FifoDepth];
    logic [31:0]          fifo_data [FifoDepth];
    logic [FifoDepth-1:0] fifo_write;
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW:0]        count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic rsp_hs;
    logic rd_hs;
    logic timeout_hit;

    assign fifo_empty  = (count == '0);
    // A full FIFO refuses a push even if the head pops in the same cycle.
    assign fifo_full   = (count == (PtrW + 1)'(FifoDepth));
    assign cmd_ready_o = !fifo_full;
    assign push        = cmd_valid_i && !fifo_full;
    assign pop         = csr_req_valid_o && csr_req_ready_i;
    assign rsp_hs      = csr_rsp_valid_i && csr_rsp_ready_o;
    assign rd_hs       = rd_valid_o && rd_ready_i;

    // Request channel shows the FIFO head; it reads as zero while empty.
    assign csr_req_valid_o = (state == REQ);
    assign csr_req_addr_o  = fifo_empty ? 32'd0 : fifo_addr[rd_ptr];
    assign csr_req_data_o  = fifo_empty ? 32'd0 : fifo_data[rd_ptr];
    assign csr_req_write_o = fifo_empty ? 1'b0  : fifo_write[rd_ptr];

    // A new response is only taken once the previous result was consumed.
    assign csr_rsp_ready_o = (state == WAIT_RSP) && !rd_valid_o;
    assign busy_o          = !fifo_empty || (state != IDLE) || rd_valid_o;

    // Command storage; entries are only observed while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cmd_addr_i;
            fifo_data[wr_ptr]  <= cmd_data_i;
            fifo_write[wr_ptr] <= cmd_write_i;
        end
    end

    // FIFO pointers and occupancy; push and pop may both happen in a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PtrW + 1)'(1);
                2'b01:   count <= count - (PtrW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a push into an idle master is issued the next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty || push) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (csr_req_ready_i) begin
                    if (!fifo_write[rd_ptr]) begin
                        state_next = WAIT_RSP;
                    end else if ((count > (PtrW + 1)'(1)) || push) begin
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if ((csr_rsp_valid_i && !rd_valid_o) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read result register, held until the host takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o  <= 32'd0;
            rd_valid_o <= 1'b0;
        end else if (rsp_hs) begin
            rd_data_o  <= csr_rsp_data_i;
            rd_valid_o <= 1'b1;
        end else if (timeout_hit) begin
            rd_data_o  <= 32'hDEAD_BEEF;
            rd_valid_o <= 1'b1;
        end else if (rd_hs) begin
            rd_valid_o <= 1'b0;
        end
    end

`ifdef SNAX_CSR_MASTER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] wait_cnt;
    logic            err_flag;

    // The clock only runs while the master is actually free to take a
    // response, so a stall behind an unconsumed result never times out.
    assign timeout_hit = (state == WAIT_RSP) && !rd_valid_o && !csr_rsp_valid_i
                         && (wait_cnt == CntW'(TimeoutCycles - 1));
    assign err_o       = err_flag;

    // Count cycles spent waiting for the current read response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state != WAIT_RSP) begin
            wait_cnt <= '0;
        end else if (!rd_valid_o) begin
            wait_cnt <= wait_cnt + CntW'(1);
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_flag <= 1'b0;
        end else if (timeout_hit) begin
            err_flag <= 1'b1;
        end
    end
`else
    // TimeoutCycles has no effect when the timeout is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign timeout_hit        = 1'b0;
    assign err_o              = 1'b0;
`endif

endmodule

`default_nettype wire
